// File: rtl/ascon_pkg.sv
// ascon_pkg: shared state encoding, sizing constants and round-constant helper for the ASCON-128 sequencer.
package ascon_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_P_INIT,
        S_KEY_INIT,
        S_AD,
        S_P_AD,
        S_DSEP,
        S_PT,
        S_P_PT,
        S_KEY_FIN,
        S_P_FIN,
        S_TAG,
        S_DONE
    } sched_state_t;

    localparam int NB_MAX_C   = 23;
    localparam int BLK_W_C    = 5;
    localparam int ROUNDS_A_C = 12;
    localparam int ROUNDS_B_C = 6;

    // Upper nibble counts down from 15 while the lower nibble counts up with the round index.
    function automatic logic [7:0] ascon_rc(input logic [3:0] r);
        return {4'hF - r, r};
    endfunction

endpackage

// File: rtl/ascon_round_sched_if.sv
// ascon_round_sched_if: control/handshake bundle between the ASCON sequencer (slave) and its datapath/host (master).
interface ascon_round_sched_if #(parameter int BLK_W = 5);

    logic             start_i;
    logic [BLK_W-1:0] n_blk_i;
    logic             pt_valid_i;
    logic             pt_ready_o;
    logic [BLK_W-1:0] blk_idx_o;
    logic             last_blk_o;
    logic             init_sel_o;
    logic             perm_en_o;
    logic [7:0]       rc_o;
    logic             xor_key_lsb_o;
    logic             xor_da_o;
    logic             xor_dsep_o;
    logic             xor_pt_o;
    logic             xor_key_fin_o;
    logic             en_cipher_reg_o;
    logic             en_tag_reg_o;
    logic             busy_o;
    logic             end_ascon_o;

    modport master (
        output start_i, n_blk_i, pt_valid_i,
        input  pt_ready_o, blk_idx_o, last_blk_o, init_sel_o, perm_en_o, rc_o,
               xor_key_lsb_o, xor_da_o, xor_dsep_o, xor_pt_o, xor_key_fin_o,
               en_cipher_reg_o, en_tag_reg_o, busy_o, end_ascon_o
    );

    modport slave (
        input  start_i, n_blk_i, pt_valid_i,
        output pt_ready_o, blk_idx_o, last_blk_o, init_sel_o, perm_en_o, rc_o,
               xor_key_lsb_o, xor_da_o, xor_dsep_o, xor_pt_o, xor_key_fin_o,
               en_cipher_reg_o, en_tag_reg_o, busy_o, end_ascon_o
    );

endinterface

// File: rtl/ascon_round_cnt.sv
// ascon_round_cnt: loadable 4-bit round counter; last_round_o flags the final round of p^a (sel_a_i=1) or p^b.
module ascon_round_cnt #(
    parameter int LIM_A = 12,
    parameter int LIM_B = 6
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       sel_a_i,
    output logic [3:0] cnt_o,
    output logic       last_round_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? 4'd0 : en_i ? cnt_q + 4'd1 : cnt_q;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) cnt_q <= 4'd0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o        = cnt_q;
    assign last_round_o = en_i && (cnt_q == (sel_a_i ? 4'(LIM_A - 1) : 4'(LIM_B - 1)));

endmodule

// File: rtl/ascon_round_sched.sv
// ascon_round_sched: ASCON-128 encryption phase sequencer issuing one permutation round per cycle.
// Optional ASCON_ABORT_EN adds abort_i, which returns any active run to IDLE at the next edge.
module ascon_round_sched
    import ascon_pkg::*;
#(
    parameter int NB_MAX   = NB_MAX_C,
    parameter int BLK_W    = BLK_W_C,
    parameter int ROUNDS_A = ROUNDS_A_C,
    parameter int ROUNDS_B = ROUNDS_B_C
) (
    input logic clock_i,
    input logic reset_i,
`ifdef ASCON_ABORT_EN
    input logic abort_i,
`endif
    ascon_round_sched_if.slave bus
);

    sched_state_t     state_q, state_d;
    logic [BLK_W-1:0] n_q, n_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [3:0]       cnt;
    logic             last_round;
    logic             perm_en;
    logic             is_pa;
    logic             hs;
    logic             last_blk;

    assign perm_en  = state_q inside {S_P_INIT, S_P_AD, S_P_PT, S_P_FIN};
    assign is_pa    = state_q inside {S_P_INIT, S_P_FIN};
    assign hs       = (state_q == S_PT) && bus.pt_valid_i;
    assign last_blk = (state_q == S_PT) && (blk_q == n_q - BLK_W'(1));

    // Clearing whenever idle or on the final round means every P_* state starts at zero.
    ascon_round_cnt #(.LIM_A(ROUNDS_A), .LIM_B(ROUNDS_B)) u_cnt (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .clr_i        (!perm_en || last_round),
        .en_i         (perm_en),
        .sel_a_i      (is_pa),
        .cnt_o        (cnt),
        .last_round_o (last_round)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        blk_d   = blk_q;
        case (state_q)
            S_IDLE: if (bus.start_i) begin
                state_d = S_LOAD;
                n_d     = (bus.n_blk_i > BLK_W'(NB_MAX)) ? BLK_W'(NB_MAX) : bus.n_blk_i;
                blk_d   = '0;
            end
            S_LOAD:     state_d = S_P_INIT;
            S_P_INIT:   state_d = last_round ? S_KEY_INIT : S_P_INIT;
            S_KEY_INIT: state_d = S_AD;
            S_AD:       state_d = S_P_AD;
            S_P_AD:     state_d = last_round ? S_DSEP : S_P_AD;
            S_DSEP:     state_d = (n_q != '0) ? S_PT : S_KEY_FIN;
            S_PT:       state_d = hs ? (last_blk ? S_KEY_FIN : S_P_PT) : S_PT;
            S_P_PT: if (last_round) begin
                state_d = S_PT;
                blk_d   = blk_q + BLK_W'(1);
            end
            S_KEY_FIN:  state_d = S_P_FIN;
            S_P_FIN:    state_d = last_round ? S_TAG : S_P_FIN;
            S_TAG:      state_d = S_DONE;
            default:    state_d = S_IDLE;
        endcase
`ifdef ASCON_ABORT_EN
        if (abort_i && state_q != S_IDLE) state_d = S_IDLE;
`endif
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            blk_q   <= blk_d;
        end
    end

    assign bus.pt_ready_o      = state_q == S_PT;
    assign bus.blk_idx_o       = blk_q;
    assign bus.last_blk_o      = last_blk;
    assign bus.init_sel_o      = state_q == S_LOAD;
    assign bus.perm_en_o       = perm_en;
    assign bus.rc_o            = perm_en ? ascon_rc(is_pa ? cnt : cnt + 4'(ROUNDS_A - ROUNDS_B)) : 8'h00;
    assign bus.xor_key_lsb_o   = state_q == S_KEY_INIT;
    assign bus.xor_da_o        = state_q == S_AD;
    assign bus.xor_dsep_o      = state_q == S_DSEP;
    assign bus.xor_pt_o        = hs;
    assign bus.xor_key_fin_o   = state_q == S_KEY_FIN;
    assign bus.en_cipher_reg_o = hs;
    assign bus.en_tag_reg_o    = state_q == S_TAG;
    assign bus.busy_o          = state_q != S_IDLE;
    assign bus.end_ascon_o     = state_q == S_DONE;

endmodule

// File: tb/tb_ascon_round_sched.sv
// tb_ascon_round_sched: scoreboard bench for the ASCON round sequencer; expected strobe events are queued
// per run and a negedge monitor pops them as the DUT raises each strobe. Honors ASCON_ABORT_EN.
module tb_ascon_round_sched;

    localparam int K_INIT = 0, K_RC = 1, K_KEYI = 2, K_AD = 3, K_DSEP = 4;
    localparam int K_XPT = 5, K_CIPH = 6, K_KEYF = 7, K_TAG = 8, K_END = 9;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef ASCON_ABORT_EN
    logic abort = 1'b0;
`endif
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    ev_t exp_q[$];
    logic [7:0] rc_tab [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
    logic [25:0] outs;

    ascon_round_sched_if bus();

    ascon_round_sched dut (
        .clock_i (clk),
        .reset_i (rst_n),
`ifdef ASCON_ABORT_EN
        .abort_i (abort),
`endif
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign outs = {bus.pt_ready_o, bus.blk_idx_o, bus.last_blk_o, bus.init_sel_o, bus.perm_en_o,
                   bus.rc_o, bus.xor_key_lsb_o, bus.xor_da_o, bus.xor_dsep_o, bus.xor_pt_o,
                   bus.xor_key_fin_o, bus.en_cipher_reg_o, bus.en_tag_reg_o, bus.busy_o,
                   bus.end_ascon_o};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic push(input int k, input int v);
        exp_q.push_back('{kind: k, val: v});
    endtask

    task automatic got(input int k, input int v);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected event kind %0d at cyc %0d: got value %0d, expected no event", k, cyc, v);
        end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk($sformatf("event kind at cyc %0d", cyc), k, e.kind);
            chk($sformatf("event kind %0d value at cyc %0d", k, cyc), v, e.val);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.init_sel_o)      got(K_INIT, cyc);
            if (bus.perm_en_o)       got(K_RC, int'(bus.rc_o));
            if (bus.xor_key_lsb_o)   got(K_KEYI, cyc);
            if (bus.xor_da_o)        got(K_AD, cyc);
            if (bus.xor_dsep_o)      got(K_DSEP, cyc);
            if (bus.xor_pt_o)        got(K_XPT, int'(bus.blk_idx_o));
            if (bus.en_cipher_reg_o) got(K_CIPH, int'(bus.blk_idx_o) * 2 + int'(bus.last_blk_o));
            if (bus.xor_key_fin_o)   got(K_KEYF, cyc);
            if (bus.en_tag_reg_o)    got(K_TAG, cyc);
            if (bus.end_ascon_o)     got(K_END, cyc);
        end
    end

    // Cycle k of a run whose start was sampled when cyc became c is observed with cyc == c+k-1.
    task automatic push_run(input int c, input int n, input int sb, input int sl);
        int k;
        push(K_INIT, c);
        for (int r = 0; r < 12; r++) push(K_RC, int'(rc_tab[r]));
        push(K_KEYI, c + 13);
        push(K_AD, c + 14);
        for (int r = 0; r < 6; r++) push(K_RC, int'(rc_tab[6 + r]));
        push(K_DSEP, c + 21);
        k = 23;
        for (int b = 0; b < n; b++) begin
            if (b == sb) k += sl;
            push(K_XPT, b);
            push(K_CIPH, b * 2 + int'(b == n - 1));
            k++;
            if (b < n - 1) begin
                for (int r = 0; r < 6; r++) push(K_RC, int'(rc_tab[6 + r]));
                k += 6;
            end
        end
        push(K_KEYF, c + k - 1);
        k++;
        for (int r = 0; r < 12; r++) push(K_RC, int'(rc_tab[r]));
        k += 12;
        push(K_TAG, c + k - 1);
        push(K_END, c + k);
    endtask

    task automatic wait_to(input int c0, input int k);
        while (cyc - c0 + 1 < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run(input int nin, output int c0);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.n_blk_i = 5'(nin);
        @(posedge clk);
        #1;
        c0 = cyc;
        bus.start_i = 1'b0;
        bus.n_blk_i = 5'd1;
    endtask

    task automatic run(input int nin, input int neff, input int sb, input int sl, input int exp_end);
        int c0;
        int rdy = 0;
        int endc = -1;
        bit stalled = 0;
        start_run(nin, c0);
        push_run(c0, neff, sb, sl);
        for (int i = 0; i < 400 && endc < 0; i++) begin
            if (sb >= 0 && !stalled && bus.pt_ready_o && bus.blk_idx_o == 5'(sb)) begin
                stalled = 1;
                bus.pt_valid_i = 1'b0;
                for (int j = 0; j < sl; j++) begin
                    chk("stall pt_ready_o", int'(bus.pt_ready_o), 1);
                    chk("stall perm_en_o", int'(bus.perm_en_o), 0);
                    chk("stall rc_o", int'(bus.rc_o), 0);
                    rdy++;
                    @(posedge clk);
                    #1;
                end
                bus.pt_valid_i = 1'b1;
            end
            if (bus.pt_ready_o) rdy++;
            if (!bus.busy_o) endc = cyc - c0 + 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (endc < 0) begin
            checks++;
            errors++;
            $display("FAIL run n=%0d timeout: busy_o still high, expected low in cycle %0d", nin, exp_end + 1);
        end else chk($sformatf("run n=%0d first idle cycle", nin), endc, exp_end + 1);
        chk($sformatf("run n=%0d pt_ready cycles", nin), rdy, neff + sl);
        chk($sformatf("run n=%0d queue drained", nin), exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        bus.start_i = 1'b0;
        bus.n_blk_i = '0;
        bus.pt_valid_i = 1'b1;
        #1;
        chk("reset outputs", int'(outs), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(23, 23, -1, 0, 192);
        run(31, 23, -1, 0, 192);
        run(4, 4, 2, 5, 64);
        run(0, 0, -1, 0, 37);

        // Asynchronous reset in the middle of block 3's p^b.
        start_run(23, c0);
        push_run(c0, 23, -1, 0);
        wait_to(c0, 50);
        chk("pre-reset blk_idx_o", int'(bus.blk_idx_o), 3);
        #1 rst_n = 1'b0;
        #1 chk("async reset outputs", int'(outs), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(1, 1, -1, 0, 38);

        // start_i held high: the following run is sampled in the single IDLE cycle after DONE.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.n_blk_i = 5'd0;
        @(posedge clk);
        #1;
        c0 = cyc;
        push_run(c0, 0, -1, 0);
        push_run(c0 + 38, 0, -1, 0);
        wait_to(c0, 38);
        chk("held start idle gap busy_o", int'(bus.busy_o), 0);
        wait_to(c0, 39);
        chk("held start rerun busy_o", int'(bus.busy_o), 1);
        bus.start_i = 1'b0;
        wait_to(c0, 76);
        chk("held start second run idle", int'(bus.busy_o), 0);
        chk("held start queue drained", exp_q.size(), 0);

`ifdef ASCON_ABORT_EN
        start_run(23, c0);
        push_run(c0, 23, -1, 0);
        wait_to(c0, 30);
        abort = 1'b1;
        wait_to(c0, 31);
        abort = 1'b0;
        chk("abort busy_o", int'(bus.busy_o), 0);
        chk("abort perm_en_o", int'(bus.perm_en_o), 0);
        exp_q.delete();
        repeat (200) @(posedge clk);
        #1 chk("abort stays idle", int'(bus.busy_o), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
